// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD engine host sequencer.
package gcd_pkg;

  localparam int unsigned DefWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StGo,
    StWait,
    StCapt,
    StFail
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = unsigned'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
  import gcd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic start_pulse
);

  localparam int unsigned CntW = clog2(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      cnt_q       <= '0;
      start_pulse <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      start_pulse <= 1'b0;
      // Any cycle agreeing with the current level restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q       <= '0;
        level_q     <= sync2_q;
        start_pulse <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/gcd_host_seq.sv
// Host-side sequencer for the subtractive GCD engine: takes a debounced start,
// clears and launches the engine, then captures its result or times out.
module gcd_host_seq
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             btn_start,
  input  logic [WIDTH-1:0] sw_x,
  input  logic [WIDTH-1:0] sw_y,
  output logic             eng_clr,
  output logic             eng_go,
  output logic [WIDTH-1:0] eng_x,
  output logic [WIDTH-1:0] eng_y,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_gcd,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             err_zero,
  output logic             err_timeout
);

  localparam int unsigned TmoW = clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e          state_q;
  logic [TmoW-1:0] tmo_q;
  logic            start_pulse;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk        (clk),
    .clr_n      (clr_n),
    .btn        (btn_start),
    .start_pulse(start_pulse)
  );

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      eng_clr      <= 1'b0;
      eng_go       <= 1'b0;
      eng_x        <= '0;
      eng_y        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err_zero     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      eng_clr <= 1'b0;
      eng_go  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            eng_x        <= sw_x;
            eng_y        <= sw_y;
            result_valid <= 1'b0;
            err_zero     <= 1'b0;
            err_timeout  <= 1'b0;
            // A zero operand would never terminate the subtractive engine.
            if (sw_x == '0 || sw_y == '0) begin
              err_zero <= 1'b1;
            end else begin
              eng_clr <= 1'b1;
              state_q <= StClr;
            end
          end
        end
        StClr: begin
          eng_go  <= 1'b1;
          state_q <= StGo;
        end
        StGo: begin
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          tmo_q <= tmo_q + TmoW'(1);
          // Result is latched on the done edge so it is visible one cycle later.
          if (eng_done) begin
            result       <= eng_gcd;
            result_valid <= 1'b1;
            state_q      <= StCapt;
          end else if (tmo_q == TmoLast) begin
            eng_clr <= 1'b1;
            state_q <= StFail;
          end
        end
        StCapt: begin
          state_q <= StIdle;
        end
        StFail: begin
          err_timeout <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_host_seq.sv
// Randomised self-checking bench for gcd_host_seq with a behavioural engine
// and a timeline-based reference model of the host.
module tb_gcd_host_seq;

  localparam int unsigned W = 8;
  localparam int D = 16;
  localparam int T = 1024;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         btn_start = 1'b0;
  logic [W-1:0] sw_x = '0;
  logic [W-1:0] sw_y = '0;
  logic         eng_clr, eng_go;
  logic [W-1:0] eng_x, eng_y, result;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_gcd = '0;
  logic         result_valid, busy, err_zero, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_host_seq #(
    .WIDTH       (W),
    .DEBOUNCE_CYC(D),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .btn_start   (btn_start),
    .sw_x        (sw_x),
    .sw_y        (sw_y),
    .eng_clr     (eng_clr),
    .eng_go      (eng_go),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_done    (eng_done),
    .eng_gcd     (eng_gcd),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .err_zero    (err_zero),
    .err_timeout (err_timeout)
  );

  function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Engine: done appears 'eng_lat' WAIT cycles after go; sticky until clear.
  int unsigned  eng_lat = 20;
  bit           eng_hang = 1'b0;
  logic         eng_active = 1'b0;
  int unsigned  eng_cnt = 0;
  logic [W-1:0] opx = '0, opy = '0;

  always @(posedge clk) begin
    if (eng_clr) begin
      eng_done   <= 1'b0;
      eng_active <= 1'b0;
    end else if (eng_go) begin
      eng_active <= 1'b1;
      eng_cnt    <= eng_lat;
      opx        <= eng_x;
      opy        <= eng_y;
    end else if (eng_active && !eng_hang) begin
      if (eng_cnt <= 1) begin
        eng_done   <= 1'b1;
        eng_gcd    <= W'(gcd_ref(opx, opy));
        eng_active <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Reference model: expected outputs for the current cycle.
  logic [W-1:0] e_x = '0, e_y = '0, e_res = '0;
  logic e_clr = 0, e_go = 0, e_valid = 0, e_busy = 0, e_ez = 0, e_et = 0;
  bit   m_run = 0, m_level = 0, m_pulse = 0, flip;
  int   m_age = 0, m_tail = 0;
  bit   hist[$];
  int   cyc = 0, clr_cnt = 0, go_cnt = 0, clr_cyc = 0, go_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (eng_clr) begin clr_cnt++; clr_cyc = cyc; end
    if (eng_go) begin go_cnt++; go_cyc = cyc; end
    if (!clr_n) begin
      {e_x, e_y, e_res} = '0;
      {e_clr, e_go, e_valid, e_busy, e_ez, e_et} = '0;
      m_run = 0; m_level = 0; m_pulse = 0; m_tail = 0;
      hist.delete();
    end
    chk("eng_clr", eng_clr, e_clr);
    chk("eng_go", eng_go, e_go);
    chk("eng_x", eng_x, e_x);
    chk("eng_y", eng_y, e_y);
    chk("result", result, e_res);
    chk("result_valid", result_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("err_zero", err_zero, e_ez);
    chk("err_timeout", err_timeout, e_et);
    if (clr_n) begin
      // Run timeline: age 1 clear, age 2 go, age 3.. waiting for done.
      e_clr = 0;
      e_go  = 0;
      if (!m_run) begin
        if (m_pulse) begin
          e_x = sw_x; e_y = sw_y; e_valid = 0; e_ez = 0; e_et = 0;
          if (sw_x == 0 || sw_y == 0) begin
            e_ez = 1;
          end else begin
            m_run = 1; m_age = 1; m_tail = 0; e_busy = 1; e_clr = 1;
          end
        end
      end else if (m_tail != 0) begin
        if (m_tail == 2) e_et = 1;
        m_run  = 0;
        e_busy = 0;
      end else begin
        if (m_age == 1) begin
          e_go = 1;
        end else if (m_age >= 3) begin
          if (eng_done) begin
            e_res = eng_gcd; e_valid = 1; m_tail = 1;
          end else if (m_age - 3 == T - 1) begin
            e_clr = 1; m_tail = 2;
          end
        end
        m_age++;
      end
      // Debounce: flip once the D raw samples reaching the counter all disagree.
      hist.push_back(btn_start);
      if (hist.size() > D + 4) void'(hist.pop_front());
      m_pulse = 0;
      if (hist.size() >= D + 2) begin
        flip = 1;
        for (int j = 0; j < D; j++) begin
          if (hist[hist.size() - 3 - j] == m_level) flip = 0;
        end
        if (flip) begin
          m_pulse = !m_level;
          m_level = !m_level;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_start = 1'b1;
    step(30);
    btn_start = 1'b0;
    step(30);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    chk("run_finished", busy, 0);
  endtask

  int go0, clr0;
  int unsigned rx, ry;

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_eng_clr", eng_clr, 0);
    clr_n = 1'b1;
    step(2);

    // Basic run
    sw_x = 36; sw_y = 24; eng_lat = 20;
    go0 = go_cnt; clr0 = clr_cnt;
    press();
    wait_idle(2000);
    chk("run1_result", result, 12);
    chk("run1_valid", result_valid, 1);
    chk("run1_errs", {err_zero, err_timeout}, 0);
    chk("run1_go_count", go_cnt - go0, 1);
    chk("run1_clr_to_go", go_cyc - clr_cyc, 1);

    // Zero operand
    sw_x = 0; sw_y = 24;
    go0 = go_cnt; clr0 = clr_cnt;
    press();
    chk("zero_err", err_zero, 1);
    chk("zero_valid", result_valid, 0);
    chk("zero_engine_quiet", (go_cnt - go0) + (clr_cnt - clr0), 0);

    // Hung engine: one clear at start, one at timeout
    sw_x = 36; sw_y = 24; eng_hang = 1;
    clr0 = clr_cnt;
    press();
    wait_idle(T + 200);
    chk("hang_timeout", err_timeout, 1);
    chk("hang_valid", result_valid, 0);
    chk("hang_clr_count", clr_cnt - clr0, 2);
    eng_hang = 0;
    sw_x = 7; sw_y = 7; eng_lat = 5;
    press();
    wait_idle(2000);
    chk("after_hang_result", result, 7);
    chk("after_hang_timeout", err_timeout, 0);

    // Done on the last allowed WAIT cycle wins; one cycle later is a timeout
    sw_x = 45; sw_y = 30; eng_lat = T - 1;
    press();
    wait_idle(T + 200);
    chk("edge_result", result, 15);
    chk("edge_no_timeout", err_timeout, 0);
    eng_lat = T;
    press();
    wait_idle(T + 200);
    chk("late_timeout", err_timeout, 1);
    chk("late_valid", result_valid, 0);

    // Bouncing button gives one run
    sw_x = 36; sw_y = 24; eng_lat = 20;
    go0 = go_cnt;
    for (int i = 0; i < 40; i += 3) begin
      btn_start = ~btn_start;
      step(3);
    end
    press();
    wait_idle(2000);
    chk("bounce_go_count", go_cnt - go0, 1);
    chk("bounce_result", result, 12);

    // Second press and switch change during WAIT are ignored
    eng_lat = 200;
    go0 = go_cnt;
    press();
    sw_x = 99;
    press();
    chk("midrun_eng_x", eng_x, 36);
    wait_idle(2000);
    chk("midrun_go_count", go_cnt - go0, 1);
    chk("midrun_result", result, 12);

    // Reset during WAIT
    sw_x = 36;
    press();
    chk("pre_reset_busy", busy, 1);
    clr_n = 1'b0;
    #1;
    chk("reset_outputs", {eng_clr, eng_go, eng_x, eng_y, result, result_valid, busy,
                          err_zero, err_timeout}, 0);
    step(3);
    clr_n = 1'b1;
    sw_x = 17; sw_y = 51; eng_lat = 30;
    step(2);
    press();
    wait_idle(2000);
    chk("post_reset_result", result, 17);
    chk("post_reset_valid", result_valid, 1);

    // Random operands and latencies
    for (int i = 0; i < 10; i++) begin
      rx = $urandom_range(1, 255);
      ry = $urandom_range(1, 255);
      if ($urandom_range(0, 7) == 0) rx = 0;
      sw_x = W'(rx); sw_y = W'(ry);
      eng_lat = $urandom_range(1, 300);
      press();
      wait_idle(T + 200);
      if (rx == 0) chk("rand_zero", err_zero, 1);
      else chk("rand_result", {result_valid, result}, {1'b1, W'(gcd_ref(rx, ry))});
    end

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_host_seq.md
Name: gcd_host_seq

Overview:
- Host-side sequencer for the subtractive GCD engine (FSM controller plus datapath); it is the initiator end of the engine's go/done interface.
- Debounces the start button and captures two operands from the Basys3 switches.
- Clears and starts the engine, waits for its done indication, then latches and presents the result.
- Guards against engine hang: rejects zero operands and enforces a cycle timeout.

Parameters:
- WIDTH, 8, operand and result width (two 8-bit operands from 16 switches).
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a button level change (board build overrides to 1_000_000).
- TIMEOUT_CYC, 1024, maximum cycles in WAIT before declaring a timeout; must exceed 3*(2^WIDTH)+4.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- btn_start  in  1  raw, asynchronous start push-button.
- sw_x  in  WIDTH  operand X from switches.
- sw_y  in  WIDTH  operand Y from switches.
- eng_clr  out  1  active-high engine clear; one-cycle pulse.
- eng_go  out  1  engine start; one-cycle pulse.
- eng_x  out  WIDTH  registered operand X to engine; held stable while busy.
- eng_y  out  WIDTH  registered operand Y to engine; held stable while busy.
- eng_done  in  1  engine result-load indication (engine gld); level, sticky until eng_clr.
- eng_gcd  in  WIDTH  engine result bus; valid while eng_done=1.
- result  out  WIDTH  latched GCD.
- result_valid  out  1  result holds a completed GCD.
- busy  out  1  high in every state except IDLE.
- err_zero  out  1  last start was rejected for a zero operand.
- err_timeout  out  1  last run exceeded TIMEOUT_CYC.

Behaviour:
- Reset (clr_n=0, async): state=IDLE. eng_clr=0, eng_go=0, eng_x=0, eng_y=0, result=0, result_valid=0, busy=0, err_zero=0, err_timeout=0. Synchronizer, debounce counter and debounced level all cleared. Reset mid-run abandons the run immediately; the engine is re-cleared by the next accepted start.
- Button path:
  - 2-flop synchronizer.
  - Debounced level changes only after DEBOUNCE_CYC consecutive cycles of the synchronized level differing from it; any bounce restarts the count.
  - start_pulse = one-cycle pulse on the debounced rising edge.
- States: IDLE, CLR, GO, WAIT, CAPT, FAIL.
- IDLE, on start_pulse (accepted start):
  - Sample sw_x/sw_y into eng_x/eng_y.
  - Clear result_valid, err_zero and err_timeout.
  - If sw_x==0 or sw_y==0: set err_zero, stay in IDLE, no engine activity.
  - Otherwise go to CLR.
- CLR: eng_clr=1 for exactly one cycle -> GO.
- GO: eng_go=1 for exactly one cycle. Timeout counter cleared -> WAIT.
- WAIT:
  - Counter increments every cycle.
  - eng_done=1 -> CAPT. This takes precedence if done and counter==TIMEOUT_CYC-1 occur in the same cycle.
  - Counter reaches TIMEOUT_CYC-1 without done -> FAIL.
- CAPT: result<=eng_gcd, result_valid<=1 -> IDLE. The engine is left in its done state.
- FAIL: err_timeout<=1, eng_clr=1 for one cycle -> IDLE.
- start_pulse while busy=1 is ignored and not queued.
- Latency:
  - start_pulse in cycle N gives eng_clr in N+1 and eng_go in N+2.
  - eng_done sampled high in cycle M gives result_valid=1 from M+1.
- result and result_valid hold until the next accepted start.
- Switch changes while busy do not affect eng_x/eng_y.
- Outputs eng_clr and eng_go are registered (glitch-free); counter width is clog2(TIMEOUT_CYC).

Decomposition:
- Package gcd_pkg holds:
  - the state enum;
  - default WIDTH;
  - the timeout bound function clog2.
- One sub-module: btn_debounce (synchronizer, counter, rising-edge pulse), parameterised by DEBOUNCE_CYC.

Test Plan:
- x=36, y=24, press start, engine model done after 20 cycles with gcd=12 -> eng_clr at N+1, eng_go at N+2, result=12, result_valid=1, busy=0, no errors.
- x=0, y=24, press -> err_zero=1; eng_clr and eng_go never pulse; result_valid=0.
- Engine model never asserts done -> after TIMEOUT_CYC cycles err_timeout=1 with a single eng_clr pulse; then press with x=7, y=7 and done -> result=7, err_timeout cleared.
- Button bounces (toggles every 3 cycles for 40 cycles, then stable high) with DEBOUNCE_CYC=16 -> exactly one start_pulse and one run.
- Second press during WAIT, and sw changed to x=99 mid-run -> ignored; eng_x stays 36; single result=12.
- clr_n low during WAIT -> all outputs 0 immediately; next press (x=17, y=51) completes with result=17.
